// File: rtl/pc_pkg.sv
// Core-wide constants shared by fetch, decode and branch logic.
package pc_pkg;

  localparam int unsigned     XLEN         = 32;
  localparam int unsigned     INSTR_BYTES  = 4;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

endpackage : pc_pkg

// File: rtl/pc_if.sv
// Fetch-address bus driven by the program counter toward instruction memory.
interface pc_if;
  import pc_pkg::*;

  logic [XLEN-1:0] o_pc;

  modport master (output o_pc);
  modport slave  (input  o_pc);

endinterface : pc_if

// File: rtl/pc.sv
// Free-running RV32 program counter: loads the reset vector under reset,
// then advances by one instruction per clock.
module pc
  import pc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = RESET_VECTOR,
  parameter logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES)
) (
  input  logic i_clk,
  input  logic i_nrst,
  pc_if.master fetch
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next_c;

  // Carry-out is dropped on purpose: wrapping past the top of memory is legal.
  assign pc_next_c = pc_q + PC_STEP;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_next_c;
    end
  end

  assign fetch.o_pc = pc_q;

endmodule : pc

// File: tb/tb_pc.sv
// Directed bench for pc: default, wrapping and custom-step instances share
// one clock and reset.
module tb_pc;

  logic clk;
  logic nrst;

  int n_checks;
  int n_fail;
  bit mon_en;

  pc_if if_def ();
  pc_if if_wrap ();
  pc_if if_par ();

  pc u_def (
    .i_clk (clk),
    .i_nrst(nrst),
    .fetch (if_def)
  );

  pc #(.RESET_ADDR(32'hFFFF_FFF8)) u_wrap (
    .i_clk (clk),
    .i_nrst(nrst),
    .fetch (if_wrap)
  );

  pc #(.RESET_ADDR(32'h8000_0000), .PC_STEP(32'd2)) u_par (
    .i_clk (clk),
    .i_nrst(nrst),
    .fetch (if_par)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        nrst;
    logic [31:0] e_def;
    logic [31:0] e_wrap;
    logic [31:0] e_par;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [31:0] e_def,
                           input logic [31:0] e_wrap, input logic [31:0] e_par);
    check({name, "_def"},  if_def.o_pc,  e_def);
    check({name, "_wrap"}, if_wrap.o_pc, e_wrap);
    check({name, "_par"},  if_par.o_pc,  e_par);
  endtask

  // Alignment and X/Z watch on every falling edge once reset has been applied.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [1:0] low;
      low = if_def.o_pc[1:0];
      check("align_def", {30'd0, low}, 32'd0);
      n_checks++;
      if ($isunknown(if_def.o_pc) || $isunknown(if_wrap.o_pc) || $isunknown(if_par.o_pc)) begin
        n_fail++;
        $display("FAIL xz: got def=%h wrap=%h par=%h expected no X/Z",
                 if_def.o_pc, if_wrap.o_pc, if_par.o_pc);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    nrst     = 1'b0;

    vecs[0] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFC, 32'h8000_0002};
    vecs[1] = '{1'b1, 32'h0000_0008, 32'h0000_0000, 32'h8000_0004};
    vecs[2] = '{1'b1, 32'h0000_000C, 32'h0000_0004, 32'h8000_0006};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFF8, 32'h8000_0000};
    vecs[4] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFC, 32'h8000_0002};
    vecs[5] = '{1'b1, 32'h0000_0008, 32'h0000_0000, 32'h8000_0004};

    // Reset held for 100 ns.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mon_en = 1'b1;
      check_all("reset_hold", 32'h0, 32'hFFFF_FFF8, 32'h8000_0000);
    end

    // Release away from the rising edge.
    #2 nrst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (i > 0) nrst = vecs[i].nrst;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_def, vecs[i].e_wrap, vecs[i].e_par);
    end

    // Free counting continues from the last restart (two edges in).
    for (int n = 3; n <= 102; n++) begin
      @(posedge clk);
      #1;
      check_all("count", 32'(4 * n), 32'(32'hFFFF_FFF8 + 32'(4 * n)),
                32'(32'h8000_0000 + 32'(2 * n)));
    end

    // Restart, count to 0x28, then reset asynchronously mid-cycle.
    nrst = 1'b0;
    #1;
    check_all("async_imm0", 32'h0, 32'hFFFF_FFF8, 32'h8000_0000);
    @(posedge clk);
    #3 nrst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      check("recount_def", if_def.o_pc, 32'(4 * k));
    end
    #2 nrst = 1'b0;
    #1;
    check_all("async_mid", 32'h0, 32'hFFFF_FFF8, 32'h8000_0000);
    @(posedge clk);
    #1;
    check_all("async_hold", 32'h0, 32'hFFFF_FFF8, 32'h8000_0000);
    #2 nrst = 1'b1;
    @(posedge clk);
    #1;
    check_all("after_async1", 32'h4, 32'hFFFF_FFFC, 32'h8000_0002);
    @(posedge clk);
    #1;
    check_all("after_async2", 32'h8, 32'h0, 32'h8000_0004);

    @(negedge clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc
